// File: rtl/bp_tlb_lite.sv
// Fully-associative translation buffer feeding the PMA check: registered 1-cycle lookup,
// fill with in-place update / lowest-free / round-robin victim, global flush, passthrough.
module bp_tlb_lite #(
   parameter int vtag_width_p = 27,
   parameter int ptag_width_p = 28,
   parameter int els_p        = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    r_v_i,
   input  logic [vtag_width_p-1:0] r_vtag_i,
   input  logic                    trans_en_i,
   input  logic                    w_v_i,
   input  logic [vtag_width_p-1:0] w_vtag_i,
   input  logic [ptag_width_p-1:0] w_ptag_i,
   input  logic                    flush_i,
   output logic                    ptag_v_o,
   output logic [ptag_width_p-1:0] ptag_o,
   output logic                    miss_v_o,
   output logic [vtag_width_p-1:0] miss_vtag_o
);

   localparam int idx_w_lp = $clog2(els_p);

   if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
      $error("bp_tlb_lite: els_p must be a power of two >= 2");
   end

   logic [els_p-1:0]        valid_q, valid_d;
   logic [vtag_width_p-1:0] entry_vtag_q [els_p];
   logic [ptag_width_p-1:0] entry_ptag_q [els_p];
   logic [idx_w_lp-1:0]     victim_q, victim_d;

   logic                    ptag_v_q, ptag_v_d;
   logic                    miss_v_q, miss_v_d;
   logic [ptag_width_p-1:0] ptag_out_q, ptag_out_d;
   logic [vtag_width_p-1:0] miss_vtag_q, miss_vtag_d;

   logic [els_p-1:0]        hit_vec;
   logic                    hit_any;
   logic [ptag_width_p-1:0] hit_ptag;
   logic                    w_match_any, free_any;
   logic [idx_w_lp-1:0]     w_match_idx, free_idx, fill_idx;

   // Lookup reads pre-edge contents; hit data is an OR of the (at most one) matching entry.
   always_comb begin
      hit_vec     = '0;
      hit_any     = 1'b0;
      hit_ptag    = '0;
      w_match_any = 1'b0;
      w_match_idx = '0;
      free_any    = 1'b0;
      free_idx    = '0;
      for (int i = els_p - 1; i >= 0; i--) begin
         if (valid_q[i] && entry_vtag_q[i] == r_vtag_i) begin
            hit_vec[i] = 1'b1;
            hit_any    = 1'b1;
            hit_ptag   = hit_ptag | entry_ptag_q[i];
         end
         if (valid_q[i] && entry_vtag_q[i] == w_vtag_i) begin
            w_match_any = 1'b1;
            w_match_idx = idx_w_lp'(i);
         end
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = idx_w_lp'(i);
         end
      end
   end

   always_comb begin
      valid_d  = valid_q;
      victim_d = victim_q;
      if (w_match_any)   fill_idx = w_match_idx;
      else if (free_any) fill_idx = free_idx;
      else               fill_idx = victim_q;
      if (flush_i) begin
         valid_d  = '0;
         victim_d = '0;
      end else if (w_v_i) begin
         valid_d[fill_idx] = 1'b1;
         if (!w_match_any && !free_any) victim_d = victim_q + idx_w_lp'(1);
      end
   end

   // Outputs are single-cycle pulses, one per r_v_i cycle; there is no ready/backpressure,
   // so a consumer must take ptag_v_o / miss_v_o in the cycle they are high.
   always_comb begin
      ptag_v_d    = 1'b0;
      miss_v_d    = 1'b0;
      ptag_out_d  = ptag_out_q;
      miss_vtag_d = miss_vtag_q;
      if (r_v_i) begin
         if (!trans_en_i) begin
            ptag_v_d   = 1'b1;
            ptag_out_d = ptag_width_p'(r_vtag_i);
         end else if (hit_any) begin
            ptag_v_d   = 1'b1;
            ptag_out_d = hit_ptag;
         end else begin
            miss_v_d    = 1'b1;
            miss_vtag_d = r_vtag_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q     <= '0;
         victim_q    <= '0;
         ptag_v_q    <= 1'b0;
         miss_v_q    <= 1'b0;
         ptag_out_q  <= '0;
         miss_vtag_q <= '0;
      end else begin
         valid_q     <= valid_d;
         victim_q    <= victim_d;
         ptag_v_q    <= ptag_v_d;
         miss_v_q    <= miss_v_d;
         ptag_out_q  <= ptag_out_d;
         miss_vtag_q <= miss_vtag_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_v_i && !flush_i) begin
         entry_vtag_q[fill_idx] <= w_vtag_i;
         entry_ptag_q[fill_idx] <= w_ptag_i;
      end
   end

   assign ptag_v_o    = ptag_v_q;
   assign ptag_o      = ptag_out_q;
   assign miss_v_o    = miss_v_q;
   assign miss_vtag_o = miss_vtag_q;

   a_single_hit: assert property (@(posedge clk_i) disable iff (reset_i)
      (r_v_i && trans_en_i) |-> $onehot0(hit_vec))
      else $error("bp_tlb_lite: multiple entries hit");

endmodule

// File: tb/tb_bp_tlb_lite.sv
// Self-checking bench for bp_tlb_lite: behavioural TLB model feeds an expected-output queue.
module tb_bp_tlb_lite;

   localparam int VW = 27;
   localparam int PW = 28;
   localparam int EL = 8;
   localparam int W  = PW + VW + 2;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          r_v_i, trans_en_i, w_v_i, flush_i;
   logic [VW-1:0] r_vtag_i, w_vtag_i;
   logic [PW-1:0] w_ptag_i;
   logic          ptag_v_o, miss_v_o;
   logic [PW-1:0] ptag_o;
   logic [VW-1:0] miss_vtag_o;

   always #5 clk_i = ~clk_i;

   bp_tlb_lite #(.vtag_width_p(VW), .ptag_width_p(PW), .els_p(EL)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .r_v_i(r_v_i), .r_vtag_i(r_vtag_i), .trans_en_i(trans_en_i),
      .w_v_i(w_v_i), .w_vtag_i(w_vtag_i), .w_ptag_i(w_ptag_i), .flush_i(flush_i),
      .ptag_v_o(ptag_v_o), .ptag_o(ptag_o), .miss_v_o(miss_v_o), .miss_vtag_o(miss_vtag_o)
   );

   int checks = 0;
   int errors = 0;

   // Packed as {ptag_v, ptag, miss_v, miss_vtag}.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   logic          m_valid [EL];
   logic [VW-1:0] m_vtag  [EL];
   logic [PW-1:0] m_ptag  [EL];
   int            m_victim;
   logic [PW-1:0] m_last_ptag;
   logic [VW-1:0] m_last_mvtag;

   task automatic model_reset();
      for (int i = 0; i < EL; i++) m_valid[i] = 1'b0;
      m_victim     = 0;
      m_last_ptag  = '0;
      m_last_mvtag = '0;
   endtask

   task automatic step(input logic r_v, input logic [VW-1:0] r_vtag, input logic trans,
                       input logic w_v, input logic [VW-1:0] w_vtag, input logic [PW-1:0] w_ptag,
                       input logic flush);
      logic e_pv, e_mv;
      int   slot;
      @(negedge clk_i);
      r_v_i = r_v; r_vtag_i = r_vtag; trans_en_i = trans;
      w_v_i = w_v; w_vtag_i = w_vtag; w_ptag_i = w_ptag; flush_i = flush;
      e_pv = 1'b0;
      e_mv = 1'b0;
      if (r_v) begin
         if (!trans) begin
            e_pv = 1'b1;
            m_last_ptag = PW'(r_vtag);
         end else begin
            slot = -1;
            for (int i = 0; i < EL; i++) if (m_valid[i] && m_vtag[i] == r_vtag) slot = i;
            if (slot >= 0) begin
               e_pv = 1'b1;
               m_last_ptag = m_ptag[slot];
            end else begin
               e_mv = 1'b1;
               m_last_mvtag = r_vtag;
            end
         end
      end
      exp_q.push_back({e_pv, m_last_ptag, e_mv, m_last_mvtag});
      if (flush) begin
         for (int i = 0; i < EL; i++) m_valid[i] = 1'b0;
         m_victim = 0;
      end else if (w_v) begin
         slot = -1;
         for (int i = 0; i < EL; i++) if (m_valid[i] && m_vtag[i] == w_vtag) slot = i;
         if (slot < 0) for (int i = EL - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
         if (slot < 0) begin
            slot = m_victim;
            m_victim = (m_victim + 1) % EL;
         end
         m_valid[slot] = 1'b1;
         m_vtag[slot]  = w_vtag;
         m_ptag[slot]  = w_ptag;
      end
      @(posedge clk_i);
      #1;
      obs_q.push_back({ptag_v_o, ptag_o, miss_v_o, miss_vtag_o});
   endtask

   task automatic lookup(input logic [VW-1:0] v, input logic trans);
      step(1'b1, v, trans, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic fill(input logic [VW-1:0] v, input logic [PW-1:0] p);
      step(1'b0, '0, 1'b1, 1'b1, v, p, 1'b0);
   endtask

   task automatic test_reset();
      logic [W-1:0] got;
      reset_i = 1'b1;
      r_v_i = 0; r_vtag_i = '0; trans_en_i = 0; w_v_i = 0; w_vtag_i = '0; w_ptag_i = '0; flush_i = 0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      got = {ptag_v_o, ptag_o, miss_v_o, miss_vtag_o};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_hold: outputs=%h required 0", got);
      end
      @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      got = {ptag_v_o, ptag_o, miss_v_o, miss_vtag_o};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_release: outputs=%h required 0", got);
      end
   endtask

   task automatic test_passthrough();
      logic [W-1:0] got, exp;
      int n = 0;
      lookup(27'h0000123, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      lookup(27'h7FFFFFF, 1'b0);
      lookup(VW'($urandom_range(0, 32'h7FFFFFF)), 1'b0);
      lookup(27'h0000123, 1'b1);
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL passthrough[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   task automatic test_miss_fill_hit();
      logic [W-1:0] got, exp;
      int n = 0;
      lookup(27'h00ABCDE, 1'b1);
      fill(27'h00ABCDE, 28'h8001234);
      lookup(27'h00ABCDE, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
      lookup(27'h00ABCDF, 1'b1);
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL miss_fill_hit[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   task automatic test_same_cycle();
      logic [W-1:0] got, exp;
      int n = 0;
      step(1'b1, 27'h5, 1'b1, 1'b1, 27'h5, 28'h55, 1'b0);
      lookup(27'h5, 1'b1);
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL same_cycle[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   task automatic test_replacement();
      logic [W-1:0] got, exp;
      int n = 0;
      step(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < EL; i++) fill(VW'(i), PW'(28'h100 + i));
      for (int i = 0; i < EL; i++) lookup(VW'(i), 1'b1);
      fill(27'h8, 28'h108);
      lookup(27'h0, 1'b1);
      lookup(27'h8, 1'b1);
      fill(27'h9, 28'h109);
      lookup(27'h1, 1'b1);
      lookup(27'h9, 1'b1);
      fill(27'h3, 28'hABC3);
      lookup(27'h3, 1'b1);
      fill(27'hA, 28'h10A);
      lookup(27'h2, 1'b1);
      lookup(27'h3, 1'b1);
      lookup(27'hA, 1'b1);
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL replacement[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] got, exp;
      int n = 0;
      step(1'b0, '0, 1'b1, 1'b1, 27'h7, 28'h777, 1'b1);
      for (int i = 0; i < 11; i++) lookup(VW'(i), 1'b1);
      for (int i = 0; i < EL; i++) fill(VW'(32'h20 + i), PW'(28'h200 + i));
      fill(27'h28, 28'h228);
      lookup(27'h20, 1'b1);
      lookup(27'h21, 1'b1);
      lookup(27'h28, 1'b1);
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL flush[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] got, exp;
      int n = 0;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, VW'($urandom_range(0, 15)), $urandom_range(0, 6) != 0,
              $urandom_range(0, 1) == 1, VW'($urandom_range(0, 15)), PW'($urandom),
              $urandom_range(0, 40) == 0);
      end
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] got, exp;
      int n = 0;
      fill(27'h31, 28'h131);
      lookup(27'h31, 1'b1);
      checks++;
      if (ptag_v_o !== 1'b1 || ptag_o !== 28'h131) begin
         errors++;
         $display("FAIL async_pre: got pv=%b ptag=%h, expected pv=1 ptag=0000131", ptag_v_o, ptag_o);
      end
      #2;
      reset_i = 1'b1;
      #1;
      got = {ptag_v_o, ptag_o, miss_v_o, miss_vtag_o};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL async_clear: outputs=%h required 0", got);
      end
      reset_i = 1'b0;
      model_reset();
      lookup(27'h31, 1'b1);
      lookup(27'h31, 1'b1);
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++; n++;
         if (got !== exp) begin
            errors++;
            $display("FAIL async_reset[%0d]: got pv=%b ptag=%h mv=%b mvtag=%h, expected pv=%b ptag=%h mv=%b mvtag=%h",
                     n, got[W-1], got[W-2:VW+1], got[VW], got[VW-1:0], exp[W-1], exp[W-2:VW+1], exp[VW], exp[VW-1:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_miss_fill_hit();
      test_same_cycle();
      test_replacement();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_tlb_lite.md
Name: bp_tlb_lite

Overview:
Small fully-associative translation buffer that sits directly upstream of the PMA check. It turns a virtual tag into the registered physical tag plus valid (ptag_v_o, ptag_o) that the PMA stage consumes combinationally in the next cycle. It supports software/PTW fills, a global flush, round-robin replacement, and a translation-disabled passthrough mode.

Parameters:
vtag_width_p, 27, virtual tag width (VA bits above the page offset).
ptag_width_p, 28, physical tag width; must be >= vtag_width_p.
els_p, 8, number of entries; power of two, >= 2.

Ports:
clk_i  in  1  clock, rising edge.
reset_i  in  1  asynchronous, active-high reset.
r_v_i  in  1  lookup request valid.
r_vtag_i  in  vtag_width_p  lookup virtual tag.
trans_en_i  in  1  1 = translate; 0 = passthrough.
w_v_i  in  1  fill valid.
w_vtag_i  in  vtag_width_p  fill virtual tag.
w_ptag_i  in  ptag_width_p  fill physical tag.
flush_i  in  1  invalidate all entries.
ptag_v_o  out  1  registered: lookup result valid (hit or passthrough).
ptag_o  out  ptag_width_p  registered physical tag.
miss_v_o  out  1  registered: lookup missed.
miss_vtag_o  out  vtag_width_p  registered vtag of the missing lookup.

Behaviour:
- Reset (async, immediate):
  - All entry valid bits clear; victim pointer = 0.
  - ptag_v_o = 0, miss_v_o = 0, ptag_o = 0, miss_vtag_o = 0.
  - Tag/data arrays need no reset.
- Lookup latency is exactly 1 cycle. A request in cycle N produces outputs in cycle N+1. Outputs are registered and drive the PMA check directly.
- Per cycle, when r_v_i = 1:
  - trans_en_i = 0: ptag_v_o <= 1, ptag_o <= zero-extended r_vtag_i, miss_v_o <= 0.
  - trans_en_i = 1, hit (exactly one valid entry with a matching vtag): ptag_v_o <= 1, ptag_o <= that entry's ptag, miss_v_o <= 0.
  - trans_en_i = 1, no hit: ptag_v_o <= 0, miss_v_o <= 1, miss_vtag_o <= r_vtag_i. On a miss, ptag_o holds its previous value.
- When r_v_i = 0: ptag_v_o <= 0 and miss_v_o <= 0; ptag_o and miss_vtag_o hold their values.
- Outputs are one-cycle pulses per request. There is no backpressure; a request may be issued every cycle.
- Fill (w_v_i = 1, flush_i = 0), target entry selected in this order:
  1. The valid entry already holding w_vtag_i: update its ptag in place. No duplicates are ever created.
  2. Otherwise the lowest-index invalid entry.
  3. Otherwise the entry at the victim pointer; the pointer then increments mod els_p.
  - The victim pointer changes only in case 3.
  - The target entry is written valid at the clock edge.
- Flush (flush_i = 1): all valid bits clear and the victim pointer resets to 0 at the edge. A fill in the same cycle is dropped.
- Same-cycle lookup and fill/flush: the lookup sees pre-edge contents (read-before-write, no bypass). A lookup of the vtag being filled therefore misses in that cycle and hits from the next cycle onward.
- trans_en_i only affects lookups. Fills and flushes behave identically in both modes.
- Assertions:
  - More than one hit is illegal; assert in simulation.
  - els_p must be a power of two.
- Reset asserted mid-operation: outputs clear immediately and contents are lost; the first request after deassertion behaves as after power-up.

Test Plan:
- Passthrough: reset, trans_en_i = 0, r_v_i = 1, r_vtag_i = 27'h0000123 -> next cycle ptag_v_o = 1, ptag_o = 28'h0000123, miss_v_o = 0.
- Cold miss then fill then hit:
  - trans_en_i = 1, lookup 27'h00ABCDE -> miss_v_o = 1, miss_vtag_o = 27'h00ABCDE.
  - Fill that vtag with ptag 28'h8001234, then lookup again -> ptag_v_o = 1, ptag_o = 28'h8001234.
- Same-cycle fill and lookup: fill vtag 27'h5 / ptag 28'h55 while looking up 27'h5 -> miss that cycle; repeating the lookup next cycle -> hit, ptag_o = 28'h55.
- Replacement:
  - Fill vtags 0..7 (all entries, pointer stays 0), then fill vtag 8 -> entry 0 replaced, so lookup of 0 misses and lookup of 8 hits.
  - Fill vtag 9 -> entry 1 replaced, so lookup of 1 misses.
  - Refilling vtag 3 with a new ptag updates in place and leaves the pointer unchanged.
- Flush priority: flush_i = 1 together with a fill of vtag 27'h7 -> afterwards every previously filled vtag and 27'h7 miss; the next fill lands in entry 0.
- Async reset mid-stream: assert reset_i between clock edges while ptag_v_o = 1 -> ptag_v_o drops without waiting for an edge; after release, a lookup of a previously filled vtag misses.
